// File: rtl/fft_bfly_sched.sv
// Radix-2 DIT FFT butterfly sequencer: walks stages and butterflies and issues one operation per handshake.
// Optional bit-reverse swap pass before the butterflies is built when FFT_BITREV_EN is defined.
module fft_bfly_sched #(
   parameter int LOGN = 3,
   parameter int AW   = LOGN,
   parameter int TW   = LOGN - 1,
   parameter int SW_W = (LOGN > 1) ? $clog2(LOGN) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            op_valid,
   input  logic            op_ready,
   output logic            op_kind,
   output logic [AW-1:0]   addr_a,
   output logic [AW-1:0]   addr_b,
   output logic [TW-1:0]   tw_idx,
   output logic [SW_W-1:0] stage,
   output logic            last
);

   localparam int KW = LOGN - 1;
   localparam logic [KW-1:0]   k_last = {KW{1'b1}};
   localparam logic [SW_W-1:0] s_last = SW_W'(LOGN - 1);
   localparam logic [AW-1:0]   one_aw = {{(AW-1){1'b0}}, 1'b1};

`ifdef FFT_BITREV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BITREV = 2'd1, BFLY = 2'd2, DONE = 2'd3} state_t;

   localparam logic [LOGN-1:0] i_last = {LOGN{1'b1}};

   function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
      logic [LOGN-1:0] r;
      for (int j = 0; j < LOGN; j++) begin
         r[j] = v[LOGN-1-j];
      end
      return r;
   endfunction

   logic [LOGN-1:0] i_r, i_s, rev_s;
   logic            op_kind_r, kind_s;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, BFLY = 2'd2, DONE = 2'd3} state_t;
`endif

   state_t          state_r, state_s;
   logic [KW-1:0]   k_r, k_s;
   logic [SW_W-1:0] s_r, s_s;
   logic            xfer_s;

   logic            busy_r, done_r, op_valid_r, last_r;
   logic [AW-1:0]   addr_a_r, addr_b_r;
   logic [TW-1:0]   tw_idx_r;
   logic [SW_W-1:0] stage_r;

   logic            busy_s, done_s, valid_s, last_s;
   logic [AW-1:0]   a_s, b_s, kx_s, half_s, pos_s, grp_s, bf_a_s;
   logic [TW-1:0]   tw_s;
   logic [SW_W-1:0] stage_s;

   assign xfer_s = op_valid_r & op_ready;

   // Next-state and loop-counter update.
   always_comb begin
      state_s = state_r;
      k_s     = k_r;
      s_s     = s_r;
`ifdef FFT_BITREV_EN
      i_s     = i_r;
`endif
      case (state_r)
         IDLE: begin
            if (start) begin
               k_s = {KW{1'b0}};
               s_s = {SW_W{1'b0}};
`ifdef FFT_BITREV_EN
               // index 0 never swaps, so the scan begins at 1
               state_s = BITREV;
               i_s     = {{(LOGN-1){1'b0}}, 1'b1};
`else
               state_s = BFLY;
`endif
            end else begin
               state_s = IDLE;
            end
         end
`ifdef FFT_BITREV_EN
         BITREV: begin
            if (!op_valid_r || op_ready) begin
               if (i_r == i_last) begin
                  state_s = BFLY;
               end else begin
                  i_s = i_r + 1'b1;
               end
            end else begin
               state_s = BITREV;
            end
         end
`endif
         BFLY: begin
            if (xfer_s) begin
               if ((s_r == s_last) && (k_r == k_last)) begin
                  state_s = DONE;
                  k_s     = {KW{1'b0}};
                  s_s     = {SW_W{1'b0}};
               end else if (k_r == k_last) begin
                  k_s = {KW{1'b0}};
                  s_s = s_r + 1'b1;
               end else begin
                  k_s = k_r + 1'b1;
               end
            end else begin
               state_s = BFLY;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Operation fields for the next cycle, derived only from the next counter values.
   always_comb begin
      kx_s    = AW'(k_s);
      half_s  = one_aw << s_s;
      pos_s   = kx_s & (half_s - one_aw);
      grp_s   = kx_s >> s_s;
      bf_a_s  = ((grp_s << s_s) << 1'b1) + pos_s;
      valid_s = 1'b0;
      a_s     = {AW{1'b0}};
      b_s     = {AW{1'b0}};
      tw_s    = {TW{1'b0}};
      stage_s = {SW_W{1'b0}};
      last_s  = 1'b0;
      busy_s  = 1'b0;
      done_s  = (state_s == DONE);
`ifdef FFT_BITREV_EN
      rev_s   = bitrev(i_s);
      kind_s  = 1'b0;
`endif
      if (state_s == BFLY) begin
         valid_s = 1'b1;
         busy_s  = 1'b1;
         a_s     = bf_a_s;
         b_s     = bf_a_s + half_s;
         tw_s    = TW'(pos_s << (s_last - s_s));
         stage_s = s_s;
         last_s  = (s_s == s_last) && (k_s == k_last);
`ifdef FFT_BITREV_EN
      end else if (state_s == BITREV) begin
         busy_s = 1'b1;
         if (i_s < rev_s) begin
            valid_s = 1'b1;
            kind_s  = 1'b1;
            a_s     = AW'(i_s);
            b_s     = AW'(rev_s);
         end else begin
            valid_s = 1'b0;
         end
`endif
      end else begin
         valid_s = 1'b0;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         k_r        <= {KW{1'b0}};
         s_r        <= {SW_W{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         op_valid_r <= 1'b0;
         addr_a_r   <= {AW{1'b0}};
         addr_b_r   <= {AW{1'b0}};
         tw_idx_r   <= {TW{1'b0}};
         stage_r    <= {SW_W{1'b0}};
         last_r     <= 1'b0;
`ifdef FFT_BITREV_EN
         i_r        <= {LOGN{1'b0}};
         op_kind_r  <= 1'b0;
`endif
      end else begin
         state_r    <= state_s;
         k_r        <= k_s;
         s_r        <= s_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         op_valid_r <= valid_s;
         addr_a_r   <= a_s;
         addr_b_r   <= b_s;
         tw_idx_r   <= tw_s;
         stage_r    <= stage_s;
         last_r     <= last_s;
`ifdef FFT_BITREV_EN
         i_r        <= i_s;
         op_kind_r  <= kind_s;
`endif
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign op_valid = op_valid_r;
   assign addr_a   = addr_a_r;
   assign addr_b   = addr_b_r;
   assign tw_idx   = tw_idx_r;
   assign stage    = stage_r;
   assign last     = last_r;
`ifdef FFT_BITREV_EN
   assign op_kind  = op_kind_r;
`else
   assign op_kind  = 1'b0;
`endif

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Directed bench for fft_bfly_sched: LOGN=3 sweeps (free-running, backpressure, reset, ignored start)
// and a LOGN=4 scale run; honours FFT_BITREV_EN when defined.
module tb_fft_bfly_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       start3, busy3, done3, valid3, ready3, kind3, last3;
   logic [2:0] a3, b3;
   logic [1:0] tw3, st3;
   logic       start4, busy4, done4, valid4, ready4, kind4, last4;
   logic [3:0] a4, b4;
   logic [2:0] tw4;
   logic [1:0] st4;

   fft_bfly_sched #(.LOGN(3)) u_dut3 (
      .clk(clk), .reset(reset), .start(start3), .busy(busy3), .done(done3),
      .op_valid(valid3), .op_ready(ready3), .op_kind(kind3), .addr_a(a3), .addr_b(b3),
      .tw_idx(tw3), .stage(st3), .last(last3)
   );

   fft_bfly_sched #(.LOGN(4)) u_dut4 (
      .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4),
      .op_valid(valid4), .op_ready(ready4), .op_kind(kind4), .addr_a(a4), .addr_b(b4),
      .tw_idx(tw4), .stage(st4), .last(last4)
   );

`ifdef FFT_BITREV_EN
   localparam int NSW = 2;
`else
   localparam int NSW = 0;
`endif
   localparam int TOT3 = 12 + NSW;

   // hand-computed LOGN=3 butterflies, stage-major, k ascending
   int tbl_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int tbl_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int tbl_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
   int sw_a   [2]  = '{1, 3};
   int sw_b   [2]  = '{4, 6};

   int err_cnt = 0;
   int chk_cnt = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      chk_cnt++;
      if (got != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // field f: 0=a 1=b 2=tw 3=stage 4=kind
   function automatic int exp_field(input int n, input int f);
      int j;
      if (n < NSW) begin
         case (f)
            0:       return sw_a[n];
            1:       return sw_b[n];
            4:       return 1;
            default: return 0;
         endcase
      end
      j = n - NSW;
      case (f)
         0:       return tbl_a[j];
         1:       return tbl_b[j];
         2:       return tbl_tw[j];
         3:       return j / 4;
         default: return 0;
      endcase
   endfunction

   task automatic check_reset_outs(input string tag);
      check_val({tag, "_busy"},  busy3,  0);
      check_val({tag, "_done"},  done3,  0);
      check_val({tag, "_valid"}, valid3, 0);
      check_val({tag, "_kind"},  kind3,  0);
      check_val({tag, "_a"},     a3,     0);
      check_val({tag, "_b"},     b3,     0);
      check_val({tag, "_tw"},    tw3,    0);
      check_val({tag, "_stage"}, st3,    0);
      check_val({tag, "_last"},  last3,  0);
   endtask

   // Caller has already sampled start; we are at the first cycle with ops possibly valid.
   task automatic run_fft3(input bit bp, input bit pulse);
      int n, cyc;
      bit stalled;
      int ha, hb, ht, hs, hk;
      n = 0; cyc = 0; stalled = 1'b0;
      ha = 0; hb = 0; ht = 0; hs = 0; hk = 0;
      while (n < TOT3 && cyc < 300) begin
         ready3 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         start3 = pulse && (cyc == 3);
         if (stalled) begin
            check_val("hold_valid", valid3, 1);
            check_val("hold_a", a3, ha);
            check_val("hold_b", b3, hb);
            check_val("hold_tw", tw3, ht);
            check_val("hold_stage", st3, hs);
            check_val("hold_kind", kind3, hk);
         end
         check_val("run_busy", busy3, 1);
         check_val("run_done", done3, 0);
         if (valid3 && ready3) begin
            check_val("op_a", a3, exp_field(n, 0));
            check_val("op_b", b3, exp_field(n, 1));
            check_val("op_tw", tw3, exp_field(n, 2));
            check_val("op_stage", st3, exp_field(n, 3));
            check_val("op_kind", kind3, exp_field(n, 4));
            check_val("op_last", last3, (n == TOT3 - 1) ? 1 : 0);
            n++;
            stalled = 1'b0;
         end else begin
            stalled = valid3;
            ha = a3; hb = b3; ht = tw3; hs = st3; hk = kind3;
         end
         tick;
         cyc++;
      end
      start3 = 1'b0;
      ready3 = 1'b1;
      check_val("xfer_count", n, TOT3);
`ifndef FFT_BITREV_EN
      if (!bp) check_val("sweep_cycles", cyc, TOT3);
`endif
      check_val("end_valid", valid3, 0);
      check_val("end_done", done3, 1);
      check_val("end_busy", busy3, 0);
      start3 = pulse;
      tick;
      start3 = 1'b0;
      check_val("post_done", done3, 0);
      check_val("post_busy", busy3, 0);
      check_val("post_valid", valid3, 0);
      tick;
      check_val("idle_valid", valid3, 0);
      check_val("idle_busy", busy3, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc, nb;
      bit got_last;
      reset = 1'b1; start3 = 1'b0; ready3 = 1'b0; start4 = 1'b0; ready4 = 1'b0;
      #12;
      check_reset_outs("rst");
      reset = 1'b0;
      tick;

      // free-running sweep
      start3 = 1'b1;
      tick;
      start3 = 1'b0;
      check_val("first_valid", valid3, 1);
      run_fft3(1'b0, 1'b0);

      // reset in the middle of stage 1
      start3 = 1'b1; ready3 = 1'b1;
      tick;
      start3 = 1'b0;
      cyc = 0;
      while (!(valid3 && st3 == 2'd1) && cyc < 50) begin
         tick;
         cyc++;
      end
      check_val("mid_stage", st3, 1);
      check_val("mid_a", a3, 0);
      check_val("mid_b", b3, 2);
      reset = 1'b1;
      #1;
      check_reset_outs("midrst");
      #2;
      reset = 1'b0;
      tick;
      start3 = 1'b1;
      tick;
      start3 = 1'b0;
      check_val("restart_valid", valid3, 1);
      check_val("restart_a", a3, exp_field(0, 0));
      check_val("restart_b", b3, exp_field(0, 1));
      check_val("restart_tw", tw3, 0);
      check_val("restart_stage", st3, 0);
      run_fft3(1'b1, 1'b0);

      // start pulsed while busy and during DONE
      start3 = 1'b1;
      tick;
      start3 = 1'b0;
      run_fft3(1'b0, 1'b1);

      // LOGN=4 scale run
      start4 = 1'b1;
      tick;
      start4 = 1'b0;
      ready4 = 1'b1;
      nb = 0; cyc = 0; got_last = 1'b0;
      while (!got_last && cyc < 200) begin
         if (valid4) begin
            if (!kind4) nb++;
            if (last4) begin
               got_last = 1'b1;
               check_val("l4_a", a4, 7);
               check_val("l4_b", b4, 15);
               check_val("l4_tw", tw4, 7);
               check_val("l4_stage", st4, 3);
            end
         end
         tick;
         cyc++;
      end
      check_val("l4_last_seen", got_last, 1);
      check_val("l4_bfly_count", nb, 32);
      check_val("l4_done", done4, 1);
      check_val("l4_valid_after", valid4, 0);
      tick;
      check_val("l4_done_pulse", done4, 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
